// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit prefix core.
package adder_pkg;

  localparam int NIBBLE_W = 32'sd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sna_state_t;

  // Number of 4-bit slices needed to cover an operand of the given width.
  function automatic int num_nib(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/adder.sv
// 4-bit parallel-prefix (Kogge-Stone) adder core, purely combinational.
// The carry-in is folded into bit 0's generate so the two prefix levels
// directly yield every bit's carry.
module adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic                g0c_s;
  logic [NIBBLE_W-1:0] l1_g_s;
  logic [NIBBLE_W-1:0] l1_p_s;
  logic [NIBBLE_W-1:0] carry_s;

  assign g_s   = a & b;
  assign p_s   = a ^ b;
  assign g0c_s = g_s[0] | (p_s[0] & cin);

  // First prefix level: span-2 group generate/propagate.
  assign l1_g_s[0] = g0c_s;
  assign l1_p_s[0] = p_s[0];
  assign l1_g_s[1] = g_s[1] | (p_s[1] & g0c_s);
  assign l1_p_s[1] = p_s[1] & p_s[0];
  assign l1_g_s[2] = g_s[2] | (p_s[2] & g_s[1]);
  assign l1_p_s[2] = p_s[2] & p_s[1];
  assign l1_g_s[3] = g_s[3] | (p_s[3] & g_s[2]);
  assign l1_p_s[3] = p_s[3] & p_s[2];

  // Second prefix level: carries into each bit position and out of bit 3.
  assign carry_s[0] = cin;
  assign carry_s[1] = g0c_s;
  assign carry_s[2] = l1_g_s[1];
  assign carry_s[3] = l1_g_s[2] | (l1_p_s[2] & g0c_s);
  assign cout       = l1_g_s[3] | (l1_p_s[3] & l1_g_s[1]);

  assign sum = p_s ^ carry_s;

endmodule

// File: rtl/serial_nibble_adder.sv
// Nibble-serial WIDTH-bit adder: streams one 4-bit slice per cycle through
// the shared prefix core, LSB nibble first, and presents the registered
// sum, carry-out and signed overflow on a valid/ready output port.
module serial_nibble_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NUM_NIB = num_nib(WIDTH);
  localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  generate
    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  sna_state_t          state_r;
  logic [WIDTH-1:0]    a_sh_r;
  logic [WIDTH-1:0]    b_sh_r;
  logic [WIDTH-1:0]    result_r;
  logic                carry_r;
  logic [CNT_W-1:0]    nib_cnt_r;
  logic [WIDTH-1:0]    out_sum_r;
  logic                out_cout_r;
  logic                out_ovf_r;
  logic                out_valid_r;
  logic                in_ready_r;

  logic [NIBBLE_W-1:0] core_sum_s;
  logic                core_cout_s;
  logic [WIDTH-1:0]    result_next_s;
  logic                ovf_next_s;

  adder u_core (
    .a    (a_sh_r[NIBBLE_W-1:0]),
    .b    (b_sh_r[NIBBLE_W-1:0]),
    .cin  (carry_r),
    .sum  (core_sum_s),
    .cout (core_cout_s)
  );

  // Next result word (new nibble enters at the top) and overflow of the final slice.
  always_comb begin
    result_next_s = (result_r >> NIBBLE_W) | (WIDTH'(core_sum_s) << (WIDTH - NIBBLE_W));
    ovf_next_s    = (a_sh_r[NIBBLE_W-1] == b_sh_r[NIBBLE_W-1]) &&
                    (core_sum_s[NIBBLE_W-1] != a_sh_r[NIBBLE_W-1]);
  end

  // Control FSM with datapath registers and registered output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      result_r    <= '0;
      carry_r     <= 1'b0;
      nib_cnt_r   <= '0;
      out_sum_r   <= '0;
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r     <= in_a;
            b_sh_r     <= in_b;
            carry_r    <= in_cin;
            nib_cnt_r  <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          result_r <= result_next_s;
          carry_r  <= core_cout_s;
          a_sh_r   <= a_sh_r >> NIBBLE_W;
          b_sh_r   <= b_sh_r >> NIBBLE_W;
          if (nib_cnt_r == LAST_NIB) begin
            out_sum_r   <= result_next_s;
            out_cout_r  <= core_cout_s;
            out_ovf_r   <= ovf_next_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            nib_cnt_r   <= nib_cnt_r + CNT_W'(1);
            state_r     <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r & ~rst;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench: WIDTH=16 and WIDTH=4 instances, directed cases with
// literal expectations plus a randomized stream against an arithmetic model.
module tb_serial_nibble_adder;

  localparam int NN16 = 4;
  localparam int NN4  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  logic        w4_in_valid = 1'b0;
  logic        w4_in_ready;
  logic [3:0]  w4_in_a = 4'h0;
  logic [3:0]  w4_in_b = 4'h0;
  logic        w4_in_cin = 1'b0;
  logic        w4_out_valid;
  logic        w4_out_ready = 1'b1;
  logic [3:0]  w4_out_sum;
  logic        w4_out_cout;
  logic        w4_out_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit chk_en   = 1'b0;
  bit stream_done = 1'b0;

  logic [17:0] q_exp[$];
  int          q_due[$];
  int          last_acc = -1000;
  logic [17:0] front;
  logic        exp_valid;

  serial_nibble_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  serial_nibble_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .in_a(w4_in_a), .in_b(w4_in_b), .in_cin(w4_in_cin), .out_valid(w4_out_valid),
    .out_ready(w4_out_ready), .out_sum(w4_out_sum), .out_cout(w4_out_cout), .out_ovf(w4_out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {ovf, cout, sum} of a w-bit add from plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
    longint lim, ua, ub, full, sa, sb, ss;
    logic   ovf, cout;
    lim  = longint'(1) << (w - 1);
    ua   = longint'(a) & (2 * lim - 1);
    ub   = longint'(b) & (2 * lim - 1);
    full = ua + ub + longint'(c);
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    ss   = sa + sb + longint'(c);
    ovf  = (ss >= lim) || (ss < -lim);
    cout = (full >= 2 * lim);
    return {ovf, cout, 16'(full & (2 * lim - 1))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'hFFFF;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Cycle-by-cycle comparison of the 16-bit instance against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      q_exp.delete();
      q_due.delete();
      last_acc = -1000;
    end else if (chk_en) begin
      exp_valid = (q_exp.size() > 0) && (cyc >= q_due[0]);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(q_exp.size() == 0));
      if (exp_valid && out_valid) begin
        front = q_exp[0];
        chk("out_sum", 32'(out_sum), 32'(front[15:0]));
        chk("out_cout", 32'(out_cout), 32'(front[16]));
        chk("out_ovf", 32'(out_ovf), 32'(front[17]));
        if (out_ready) begin
          void'(q_exp.pop_front());
          void'(q_due.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (last_acc > -1000) chk("interval_ok", 32'(cyc - last_acc >= NN16 + 2), 32'd1);
        last_acc = cyc;
        q_exp.push_back(model(16, in_a, in_b, in_cin));
        q_due.push_back(cyc + NN16 + 1);
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    bit got = 1'b0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && !rst) begin acc_cyc = cyc; got = 1'b1; break; end
    end
    if (!got) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out16();
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) chk("out_valid_timeout", 32'd0, 32'd1);
    else chk("latency16", 32'(cyc - acc_cyc), 32'(NN16 + 1));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input logic eo);
    send16(a, b, c);
    wait_out16();
    chk("lit_sum", 32'(out_sum), 32'(es));
    chk("lit_cout", 32'(out_cout), 32'(ec));
    chk("lit_ovf", 32'(out_ovf), 32'(eo));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    bit got = 1'b0;
    int acc4 = 0;
    logic [17:0] e;
    w4_in_a = a; w4_in_b = b; w4_in_cin = c; w4_in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (w4_in_ready) begin acc4 = cyc; got = 1'b1; break; end
    end
    if (!got) chk("w4_in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    w4_in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w4_out_valid) begin got = 1'b1; break; end
    end
    if (!got) chk("w4_out_valid_timeout", 32'd0, 32'd1);
    else begin
      e = model(4, {12'h0, a}, {12'h0, b}, c);
      chk("w4_latency", 32'(cyc - acc4), 32'(NN4 + 1));
      chk("w4_sum", 32'(w4_out_sum), 32'(e[3:0]));
      chk("w4_cout", 32'(w4_out_cout), 32'(e[16]));
      chk("w4_ovf", 32'(w4_out_ovf), 32'(e[17]));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("w4_rst_in_ready", 32'(w4_in_ready), 32'd1);
    @(posedge clk); #1;

    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: result must hold while out_ready is low, no second capture.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_sum", 32'(out_sum), 32'h5556);
      chk("bp_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    @(posedge clk); #1;
    send16(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    op16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Four-bit instance: single-nibble operation.
    @(posedge clk); #1;
    op4(4'hF, 4'hF, 1'b1);
    chk("w4_lit_sum", 32'(w4_out_sum), 32'hF);
    chk("w4_lit_cout_ovf", 32'({w4_out_cout, w4_out_ovf}), 32'b10);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      op4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Randomized back-to-back stream with random output backpressure.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 1000; i++) send16(pick16(), pick16(), 1'($urandom));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (q_exp.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 32'(q_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
